fix_session_engine: RTL and testbench
=====================================

FIX_SESSION_ENGINE -- requirements
Module: fix_session_engine

Interface
REQ-001 Parameters SHALL be: NUM_SESS (default 8) = number of sessions; SID_W (default 3) = session-id width, with 2^SID_W >= NUM_SESS; HB_TICKS (default 1000) = idle cycles before timeout; CMD_DEPTH (default 4) = command FIFO depth.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock.
- rst, in, 1: asynchronous, active-low reset.
- msg_valid_i, in, 1: a received message is presented.
- msg_ready_o, out, 1: high = message accepted this cycle.
- msg_sess_i, in, SID_W: session of the message.
- msg_type_i, in, 4: 1 logon, 2 heartbeat, 3 resendReq, 4 logout, 5 reset, 6 gapFill, 7 business.
- msg_validity_i, in, 3: 0 valid, 1 seqHigh, 2 garbled, 3 seqLow, 4 invalid.
- ctl_valid_i, in, 1: control request.
- ctl_ready_o, out, 1: control request accepted.
- ctl_op_i, in, 2: 1 connect, 2 end, 3 resend_done.
- ctl_sess_i, in, SID_W: session of the control request.
- cmd_valid_o, out, 1: message-create command available.
- cmd_ready_i, in, 1: consumer takes the command.
- cmd_type_o, out, 4: message type to create.
- cmd_sess_o, out, SID_W: target session.
- disc_o, out, 1: one-cycle disconnect pulse.
- seq_upd_o, out, 1: one-cycle sequence-counter update pulse.
- app_msg_o, out, 1: one-cycle business-message pulse.
- evt_sess_o, out, SID_W: session for disc_o, seq_upd_o or app_msg_o.

Function
REQ-003 Each session SHALL hold a 3-bit state: DISC 0, LOGON_SENT 1, NORMAL 2, HB_SENT 3, RESEND 4, RESEND_LO 5, LOGOUT_SENT 6.
REQ-004 At most one event SHALL be processed per cycle, and only when the command FIFO is not full. Priority: message > control > pending timeout (lowest session index first).
REQ-005 msg_ready_o SHALL equal (FIFO not full). ctl_ready_o SHALL equal (FIFO not full and no message accepted this cycle).
REQ-006 An event SHALL push at most one command. The command SHALL be visible on cmd_valid_o the cycle after the event (first-word-fall-through). It SHALL pop when cmd_valid_o and cmd_ready_i are both high.
REQ-007 A message with seqLow or invalid validity SHALL, in any state except DISC: pulse disc_o, move the session to DISC, and push no command.
REQ-008 A message with garbled validity SHALL cause no state change, no output, and no timer reload.
REQ-009 A message for a session in DISC SHALL be accepted and discarded.
REQ-010 LOGON_SENT transitions:
- logon/valid -> NORMAL.
- logon/seqHigh -> push resendReq, go to RESEND.
- anything else -> disc_o, go to DISC.
REQ-011 NORMAL and HB_SENT transitions:
- logout/valid -> push logout, go to DISC.
- logout/seqHigh -> push resendReq, go to RESEND_LO.
- resendReq -> push gapFill, go to NORMAL.
- other seqHigh -> push resendReq, go to RESEND.
- heartbeat -> NORMAL.
- business -> pulse app_msg_o, go to NORMAL.
REQ-012 RESEND and RESEND_LO transitions:
- seqHigh on any type except reset -> push resendReq, state unchanged.
- gapFill or reset -> pulse seq_upd_o, state unchanged.
- other -> ignored.
REQ-013 LOGOUT_SENT transitions:
- logout -> disc_o, go to DISC.
- resendReq -> push gapFill, state unchanged.
- other valid message -> disc_o, go to DISC.
REQ-014 Control operations:
- connect in DISC -> push logon, go to LOGON_SENT.
- end in NORMAL or HB_SENT -> push logout, go to LOGOUT_SENT.
- resend_done in RESEND -> NORMAL.
- resend_done in RESEND_LO -> push logout, go to LOGOUT_SENT.
- any other combination -> accepted, no effect.
REQ-015 Each session SHALL have an idle counter wide enough for HB_TICKS. It SHALL reload to HB_TICKS-1 on entry to a non-DISC state and on every accepted non-garbled message. It SHALL decrement each cycle while the session is not in DISC.
REQ-016 When a counter reaches 0, the session's pending-timeout flag SHALL be set and the counter SHALL hold at 0. The flag SHALL clear when the timeout is serviced or the counter reloads.
REQ-017 A serviced timeout SHALL act as follows:
- NORMAL -> push heartbeat, go to HB_SENT, reload counter.
- LOGON_SENT, HB_SENT or LOGOUT_SENT -> disc_o, go to DISC.
- RESEND or RESEND_LO -> push resendReq, reload counter.
REQ-018 If a message and a pending timeout target the same session in the same cycle, only the message SHALL be processed, and its reload SHALL clear the pending flag.
REQ-019 evt_sess_o SHALL be 0 whenever disc_o, seq_upd_o and app_msg_o are all low.
REQ-020 A session id >= NUM_SESS SHALL be accepted and ignored.

Reset
REQ-021 While rst is low:
- all sessions SHALL be in DISC;
- all counters and pending flags SHALL be cleared;
- the FIFO SHALL be empty;
- cmd_valid_o, disc_o, seq_upd_o and app_msg_o SHALL be 0;
- cmd_type_o, cmd_sess_o and evt_sess_o SHALL be 0.
REQ-022 Reset asserted mid-operation SHALL discard queued commands immediately.
REQ-023 The first event SHALL be accepted on the first clk edge after rst deasserts.

Verification
REQ-024 Connect session 2, then logon/valid -> cmd (1, 2) one cycle after the connect; session 2 reaches NORMAL; no disc_o.
REQ-025 Session 0 in NORMAL, HB_TICKS=16, no traffic -> heartbeat cmd (2, 0) after 16 cycles; with still no traffic, disc_o and evt_sess_o=0 after 16 more cycles.
REQ-026 Session 1 in NORMAL, logout/seqHigh -> resendReq cmd; then gapFill -> seq_upd_o; then resend_done -> logout cmd; state LOGOUT_SENT.
REQ-027 Hold cmd_ready_i=0 with CMD_DEPTH=4 and four commands queued -> msg_ready_o=0; one pop -> msg_ready_o=1 the same cycle.
REQ-028 seqLow message to session 3 in HB_SENT -> disc_o with evt_sess_o=3, no command; a following business message to session 3 -> no output.
REQ-029 Assert rst with three commands queued -> cmd_valid_o=0 immediately; all sessions read DISC.

Source files
------------

// File: rtl/fix_session_engine.sv
// FIX session-layer engine: per-session state machines sharing one event slot
// per cycle, with idle timers and a first-word-fall-through command FIFO.
module fix_session_engine #(
    parameter int NUM_SESS  = 8,
    parameter int SID_W     = 3,
    parameter int HB_TICKS  = 1000,
    parameter int CMD_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  msg_valid_i,
    output logic                  msg_ready_o,
    input  logic [SID_W-1:0]      msg_sess_i,
    input  logic [3:0]            msg_type_i,
    input  logic [2:0]            msg_validity_i,
    input  logic                  ctl_valid_i,
    output logic                  ctl_ready_o,
    input  logic [1:0]            ctl_op_i,
    input  logic [SID_W-1:0]      ctl_sess_i,
    output logic                  cmd_valid_o,
    input  logic                  cmd_ready_i,
    output logic [3:0]            cmd_type_o,
    output logic [SID_W-1:0]      cmd_sess_o,
    output logic                  disc_o,
    output logic                  seq_upd_o,
    output logic                  app_msg_o,
    output logic [SID_W-1:0]      evt_sess_o,
    output logic [3*NUM_SESS-1:0] dbg_state_o
);
    typedef enum logic [2:0] {
        S_DISC = 3'd0, S_LOGON_SENT = 3'd1, S_NORMAL = 3'd2, S_HB_SENT = 3'd3,
        S_RESEND = 3'd4, S_RESEND_LO = 3'd5, S_LOGOUT_SENT = 3'd6
    } sess_state_e;

    localparam logic [3:0] T_LOGON = 4'd1, T_HEARTBEAT = 4'd2, T_RESEND_REQ = 4'd3,
                           T_LOGOUT = 4'd4, T_RESET = 4'd5, T_GAP_FILL = 4'd6,
                           T_BUSINESS = 4'd7;
    localparam logic [2:0] V_VALID = 3'd0, V_SEQ_HIGH = 3'd1, V_SEQ_LOW = 3'd3,
                           V_INVALID = 3'd4;
    localparam logic [1:0] OP_CONNECT = 2'd1, OP_END = 2'd2, OP_RESEND_DONE = 2'd3;
    localparam int TW = $clog2(HB_TICKS + 1);
    localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CW = $clog2(CMD_DEPTH + 1);
    localparam logic [TW-1:0] RELOAD  = TW'(HB_TICKS - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(CMD_DEPTH);

    sess_state_e         state_q [NUM_SESS];
    sess_state_e         state_d [NUM_SESS];
    logic [TW-1:0]       cnt_q   [NUM_SESS];
    logic [TW-1:0]       cnt_d   [NUM_SESS];
    logic [NUM_SESS-1:0] pend_q, pend_d, ev_hit;

    logic [3:0]       fifo_type_q [CMD_DEPTH];
    logic [SID_W-1:0] fifo_sess_q [CMD_DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;

    logic             pop, full, msg_acc, ctl_acc, tmo_acc, tmo_any, ev_valid, sess_ok;
    logic [SID_W-1:0] ev_sess, tmo_sess, evt_sess_q;
    sess_state_e      cur_st, nxt_st;
    logic             push, push_en, disc_d, seq_d, app_d, reload;
    logic [3:0]       push_type;
    logic             disc_q, seq_q, app_q;

    // Handshakes: a message/control/command transfers on a cycle where its valid
    // and ready are both high; ready never waits on the same channel's valid.
    // A pop in the same cycle frees a slot, so a full FIFO can still take an event.
    assign pop         = (count_q != '0) && cmd_ready_i;
    assign full        = (count_q == DEPTH_C) && !pop;
    assign msg_ready_o = !full;
    assign ctl_ready_o = !full && !msg_valid_i;
    assign msg_acc     = msg_valid_i && !full;
    assign ctl_acc     = ctl_valid_i && ctl_ready_o;
    assign tmo_acc     = tmo_any && !full && !msg_valid_i && !ctl_valid_i;
    assign ev_valid    = msg_acc || ctl_acc || tmo_acc;
    assign ev_sess     = msg_acc ? msg_sess_i : (ctl_acc ? ctl_sess_i : tmo_sess);
    assign push_en     = ev_valid && push;

    generate
        if (NUM_SESS >= (1 << SID_W)) begin : g_all_sess
            assign sess_ok = 1'b1;
        end else begin : g_sess_chk
            assign sess_ok = ({1'b0, ev_sess} < (SID_W + 1)'(NUM_SESS));
        end
        for (genvar g = 0; g < NUM_SESS; g++) begin : g_dbg
            assign dbg_state_o[3*g +: 3] = state_q[g];
        end
    endgenerate

    always_comb begin
        tmo_any  = 1'b0;
        tmo_sess = '0;
        for (int i = NUM_SESS - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                tmo_any  = 1'b1;
                tmo_sess = SID_W'(i);
            end
        end
    end

    always_comb begin
        cur_st    = state_q[ev_sess];
        nxt_st    = cur_st;
        push      = 1'b0;
        push_type = '0;
        disc_d    = 1'b0;
        seq_d     = 1'b0;
        app_d     = 1'b0;
        reload    = 1'b0;
        if (ev_valid && sess_ok) begin
            if (msg_acc) begin
                if (cur_st != S_DISC) begin
                    if (msg_validity_i == V_SEQ_LOW || msg_validity_i == V_INVALID) begin
                        disc_d = 1'b1;
                        nxt_st = S_DISC;
                    end else if (msg_validity_i == V_VALID || msg_validity_i == V_SEQ_HIGH) begin
                        reload = 1'b1;
                        case (cur_st)
                            S_LOGON_SENT: begin
                                if (msg_type_i == T_LOGON && msg_validity_i == V_VALID) begin
                                    nxt_st = S_NORMAL;
                                end else if (msg_type_i == T_LOGON) begin
                                    push = 1'b1; push_type = T_RESEND_REQ; nxt_st = S_RESEND;
                                end else begin
                                    disc_d = 1'b1; nxt_st = S_DISC;
                                end
                            end
                            S_NORMAL, S_HB_SENT: begin
                                if (msg_type_i == T_LOGOUT && msg_validity_i == V_VALID) begin
                                    push = 1'b1; push_type = T_LOGOUT; nxt_st = S_DISC;
                                end else if (msg_type_i == T_LOGOUT) begin
                                    push = 1'b1; push_type = T_RESEND_REQ; nxt_st = S_RESEND_LO;
                                end else if (msg_type_i == T_RESEND_REQ) begin
                                    push = 1'b1; push_type = T_GAP_FILL; nxt_st = S_NORMAL;
                                end else if (msg_validity_i == V_SEQ_HIGH) begin
                                    push = 1'b1; push_type = T_RESEND_REQ; nxt_st = S_RESEND;
                                end else if (msg_type_i == T_HEARTBEAT) begin
                                    nxt_st = S_NORMAL;
                                end else if (msg_type_i == T_BUSINESS) begin
                                    app_d = 1'b1; nxt_st = S_NORMAL;
                                end
                            end
                            S_RESEND, S_RESEND_LO: begin
                                if (msg_validity_i == V_SEQ_HIGH && msg_type_i != T_RESET) begin
                                    push = 1'b1; push_type = T_RESEND_REQ;
                                end else if (msg_type_i == T_GAP_FILL || msg_type_i == T_RESET) begin
                                    seq_d = 1'b1;
                                end
                            end
                            S_LOGOUT_SENT: begin
                                if (msg_type_i == T_LOGOUT) begin
                                    disc_d = 1'b1; nxt_st = S_DISC;
                                end else if (msg_type_i == T_RESEND_REQ) begin
                                    push = 1'b1; push_type = T_GAP_FILL;
                                end else if (msg_validity_i == V_VALID) begin
                                    disc_d = 1'b1; nxt_st = S_DISC;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end else if (ctl_acc) begin
                case (ctl_op_i)
                    OP_CONNECT: if (cur_st == S_DISC) begin
                        push = 1'b1; push_type = T_LOGON; nxt_st = S_LOGON_SENT;
                    end
                    OP_END: if (cur_st == S_NORMAL || cur_st == S_HB_SENT) begin
                        push = 1'b1; push_type = T_LOGOUT; nxt_st = S_LOGOUT_SENT;
                    end
                    OP_RESEND_DONE: if (cur_st == S_RESEND) begin
                        nxt_st = S_NORMAL;
                    end else if (cur_st == S_RESEND_LO) begin
                        push = 1'b1; push_type = T_LOGOUT; nxt_st = S_LOGOUT_SENT;
                    end
                    default: ;
                endcase
            end else begin
                case (cur_st)
                    S_NORMAL: begin
                        push = 1'b1; push_type = T_HEARTBEAT; nxt_st = S_HB_SENT; reload = 1'b1;
                    end
                    S_LOGON_SENT, S_HB_SENT, S_LOGOUT_SENT: begin
                        disc_d = 1'b1; nxt_st = S_DISC;
                    end
                    S_RESEND, S_RESEND_LO: begin
                        push = 1'b1; push_type = T_RESEND_REQ; reload = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (nxt_st != cur_st && nxt_st != S_DISC) reload = 1'b1;
        end
    end

    // A session in DISC never times out, so leaving for DISC also drops its timer.
    always_comb begin
        for (int i = 0; i < NUM_SESS; i++) begin
            ev_hit[i]  = ev_valid && sess_ok && (ev_sess == SID_W'(i));
            state_d[i] = ev_hit[i] ? nxt_st : state_q[i];
            cnt_d[i]   = cnt_q[i];
            pend_d[i]  = pend_q[i];
            if (state_d[i] == S_DISC) begin
                cnt_d[i]  = '0;
                pend_d[i] = 1'b0;
            end else if (ev_hit[i] && reload) begin
                cnt_d[i]  = RELOAD;
                pend_d[i] = 1'b0;
            end else begin
                if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 1'b1;
                if (cnt_q[i] <= TW'(1)) pend_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SESS; i++) begin
                state_q[i] <= S_DISC;
                cnt_q[i]   <= '0;
            end
            pend_q     <= '0;
            disc_q     <= 1'b0;
            seq_q      <= 1'b0;
            app_q      <= 1'b0;
            evt_sess_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SESS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pend_q     <= pend_d;
            disc_q     <= disc_d;
            seq_q      <= seq_d;
            app_q      <= app_d;
            evt_sess_q <= (disc_d || seq_d || app_d) ? ev_sess : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CMD_DEPTH; i++) begin
                fifo_type_q[i] <= '0;
                fifo_sess_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                fifo_type_q[wr_ptr_q] <= push_type;
                fifo_sess_q[wr_ptr_q] <= ev_sess;
                wr_ptr_q <= (wr_ptr_q == PW'(CMD_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= (rd_ptr_q == PW'(CMD_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push_en) - CW'(pop);
        end
    end

    assign cmd_valid_o = (count_q != '0);
    assign cmd_type_o  = cmd_valid_o ? fifo_type_q[rd_ptr_q] : '0;
    assign cmd_sess_o  = cmd_valid_o ? fifo_sess_q[rd_ptr_q] : '0;
    assign disc_o      = disc_q;
    assign seq_upd_o   = seq_q;
    assign app_msg_o   = app_q;
    assign evt_sess_o  = evt_sess_q;
endmodule

// File: tb/tb_fix_session_engine.sv
// Bench for fix_session_engine: directed session scenarios plus random traffic,
// checked every cycle against a timestamp-based behavioural session model.
module tb_fix_session_engine;
    localparam int NUM_SESS  = 8;
    localparam int SID_W     = 3;
    localparam int HB_TICKS  = 16;
    localparam int CMD_DEPTH = 4;
    localparam int CW        = 4 + SID_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic msg_valid_i = 1'b0, ctl_valid_i = 1'b0, cmd_ready_i = 1'b0;
    logic [SID_W-1:0] msg_sess_i = '0, ctl_sess_i = '0;
    logic [3:0] msg_type_i = '0;
    logic [2:0] msg_validity_i = '0;
    logic [1:0] ctl_op_i = '0;
    logic msg_ready_o, ctl_ready_o, cmd_valid_o, disc_o, seq_upd_o, app_msg_o;
    logic [3:0] cmd_type_o;
    logic [SID_W-1:0] cmd_sess_o, evt_sess_o;
    logic [3*NUM_SESS-1:0] dbg_state_o;

    fix_session_engine #(
        .NUM_SESS(NUM_SESS), .SID_W(SID_W), .HB_TICKS(HB_TICKS), .CMD_DEPTH(CMD_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o), .msg_sess_i(msg_sess_i),
        .msg_type_i(msg_type_i), .msg_validity_i(msg_validity_i),
        .ctl_valid_i(ctl_valid_i), .ctl_ready_o(ctl_ready_o), .ctl_op_i(ctl_op_i),
        .ctl_sess_i(ctl_sess_i),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_type_o(cmd_type_o),
        .cmd_sess_o(cmd_sess_o),
        .disc_o(disc_o), .seq_upd_o(seq_upd_o), .app_msg_o(app_msg_o),
        .evt_sess_o(evt_sess_o), .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [CW-1:0] exp_q[$];
    logic [5:0] exp_pulse = '0;
    int ms [NUM_SESS];
    int last_rl [NUM_SESS];
    int ncyc = 0;

    typedef struct {
        int nxt; bit push; int ptype; bit disc; bit sequ; bit app; bit reload;
    } eff_t;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    // Timer modelled as elapsed cycles since the last reload.
    function automatic bit pending(int i);
        return ms[i] != 0 && (ncyc - last_rl[i]) >= HB_TICKS - 1;
    endfunction

    function automatic logic [3*NUM_SESS-1:0] pack_states();
        logic [3*NUM_SESS-1:0] p = '0;
        for (int i = 0; i < NUM_SESS; i++) p[3*i +: 3] = 3'(ms[i]);
        return p;
    endfunction

    function automatic eff_t on_msg(int st, int t, int v);
        eff_t e = '{st, 0, 0, 0, 0, 0, 0};
        if (st == 0) return e;
        if (v == 3 || v == 4) begin e.disc = 1; e.nxt = 0; return e; end
        if (v != 0 && v != 1) return e;
        e.reload = 1;
        if (st == 1) begin
            if (t == 1 && v == 0) e.nxt = 2;
            else if (t == 1) begin e.push = 1; e.ptype = 3; e.nxt = 4; end
            else begin e.disc = 1; e.nxt = 0; end
        end else if (st == 2 || st == 3) begin
            if (t == 4) begin e.push = 1; e.ptype = (v == 0) ? 4 : 3; e.nxt = (v == 0) ? 0 : 5; end
            else if (t == 3) begin e.push = 1; e.ptype = 6; e.nxt = 2; end
            else if (v == 1) begin e.push = 1; e.ptype = 3; e.nxt = 4; end
            else if (t == 2) e.nxt = 2;
            else if (t == 7) begin e.app = 1; e.nxt = 2; end
        end else if (st == 4 || st == 5) begin
            if (v == 1 && t != 5) begin e.push = 1; e.ptype = 3; end
            else if (t == 6 || t == 5) e.sequ = 1;
        end else if (st == 6) begin
            if (t == 4) begin e.disc = 1; e.nxt = 0; end
            else if (t == 3) begin e.push = 1; e.ptype = 6; end
            else if (v == 0) begin e.disc = 1; e.nxt = 0; end
        end
        return e;
    endfunction

    function automatic eff_t on_ctl(int st, int op);
        eff_t e = '{st, 0, 0, 0, 0, 0, 0};
        if (op == 1 && st == 0) begin e.push = 1; e.ptype = 1; e.nxt = 1; end
        else if (op == 2 && (st == 2 || st == 3)) begin e.push = 1; e.ptype = 4; e.nxt = 6; end
        else if (op == 3 && st == 4) e.nxt = 2;
        else if (op == 3 && st == 5) begin e.push = 1; e.ptype = 4; e.nxt = 6; end
        return e;
    endfunction

    function automatic eff_t on_tmo(int st);
        eff_t e = '{st, 0, 0, 0, 0, 0, 0};
        if (st == 2) begin e.push = 1; e.ptype = 2; e.nxt = 3; end
        else if (st == 1 || st == 3 || st == 6) begin e.disc = 1; e.nxt = 0; end
        else if (st == 4 || st == 5) begin e.push = 1; e.ptype = 3; e.reload = 1; end
        return e;
    endfunction

    task automatic check_outputs();
        bit pop, full;
        pop  = exp_q.size() != 0 && cmd_ready_i;
        full = exp_q.size() == CMD_DEPTH && !pop;
        check_eq("msg_ready", 32'(msg_ready_o), 32'(!full));
        check_eq("ctl_ready", 32'(ctl_ready_o), 32'(!full && !msg_valid_i));
        check_eq("cmd_valid", 32'(cmd_valid_o), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) check_eq("cmd_word", 32'({cmd_type_o, cmd_sess_o}), 32'(exp_q[0]));
        check_eq("pulses", 32'({disc_o, seq_upd_o, app_msg_o, evt_sess_o}), 32'(exp_pulse));
        check_eq("states", 32'(dbg_state_o), 32'(pack_states()));
    endtask

    task automatic model_step();
        bit pop, full, macc, cacc, tacc;
        int tsess, sid, st;
        eff_t e = '{0, 0, 0, 0, 0, 0, 0};
        pop  = exp_q.size() != 0 && cmd_ready_i;
        full = exp_q.size() == CMD_DEPTH && !pop;
        macc = msg_valid_i && !full;
        cacc = ctl_valid_i && !full && !msg_valid_i;
        tsess = -1;
        for (int i = NUM_SESS - 1; i >= 0; i--) if (pending(i)) tsess = i;
        tacc = tsess >= 0 && !full && !msg_valid_i && !ctl_valid_i;
        sid = macc ? int'(msg_sess_i) : (cacc ? int'(ctl_sess_i) : tsess);
        if (macc || cacc || tacc) begin
            st = ms[sid];
            if (macc) e = on_msg(st, int'(msg_type_i), int'(msg_validity_i));
            else if (cacc) e = on_ctl(st, int'(ctl_op_i));
            else e = on_tmo(st);
            if (e.nxt != st && e.nxt != 0) e.reload = 1;
            ms[sid] = e.nxt;
            if (e.reload) last_rl[sid] = ncyc + 1;
        end
        if (pop) void'(exp_q.pop_front());
        if (e.push) exp_q.push_back({4'(e.ptype), SID_W'(sid)});
        exp_pulse = {e.disc, e.sequ, e.app, (e.disc || e.sequ || e.app) ? SID_W'(sid) : SID_W'(0)};
        ncyc++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        #1;
        check_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_idle();
        msg_valid_i = 1'b0; msg_sess_i = '0; msg_type_i = '0; msg_validity_i = '0;
        ctl_valid_i = 1'b0; ctl_sess_i = '0; ctl_op_i = '0;
    endtask

    task automatic send_msg(input int sid, input int t, input int v);
        msg_valid_i = 1'b1; msg_sess_i = SID_W'(sid); msg_type_i = 4'(t); msg_validity_i = 3'(v);
        tick();
        set_idle();
    endtask

    task automatic send_ctl(input int sid, input int op);
        ctl_valid_i = 1'b1; ctl_sess_i = SID_W'(sid); ctl_op_i = 2'(op);
        tick();
        set_idle();
    endtask

    task automatic idle(input int n);
        set_idle();
        repeat (n) tick();
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b0;
        #1;
        check_eq("rst_cmd_valid", 32'(cmd_valid_o), 32'd0);
        check_eq("rst_cmd_word", 32'({cmd_type_o, cmd_sess_o}), 32'd0);
        check_eq("rst_pulses", 32'({disc_o, seq_upd_o, app_msg_o, evt_sess_o}), 32'd0);
        check_eq("rst_states", 32'(dbg_state_o), 32'd0);
        exp_q.delete();
        exp_pulse = '0;
        for (int i = 0; i < NUM_SESS; i++) begin ms[i] = 0; last_rl[i] = 0; end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        @(negedge clk);
        cmd_ready_i = 1'b1;
        do_reset();

        // Connect then logon on session 2.
        send_ctl(2, 1);
        #1 check_eq("logon_cmd", 32'({cmd_valid_o, cmd_type_o, cmd_sess_o}), {24'd0, 1'b1, 4'd1, 3'd2});
        send_msg(2, 1, 0);
        #1 check_eq("s2_normal", 32'(dbg_state_o[8:6]), 32'd2);
        check_eq("s2_no_disc", 32'(disc_o), 32'd0);

        // Idle timeout: heartbeat after HB_TICKS, disconnect after another HB_TICKS.
        do_reset();
        send_ctl(0, 1);
        send_msg(0, 1, 0);
        idle(16);
        #1 check_eq("hb_cmd", 32'({cmd_valid_o, cmd_type_o, cmd_sess_o}), {24'd0, 1'b1, 4'd2, 3'd0});
        idle(16);
        #1 check_eq("hb_disc", 32'({disc_o, evt_sess_o}), {28'd0, 1'b1, 3'd0});

        // Logout with a gap: resend, gap fill, resend done, logout.
        do_reset();
        send_ctl(1, 1);
        send_msg(1, 1, 0);
        send_msg(1, 4, 1);
        #1 check_eq("rlo_cmd", 32'({cmd_valid_o, cmd_type_o, cmd_sess_o}), {24'd0, 1'b1, 4'd3, 3'd1});
        check_eq("rlo_state", 32'(dbg_state_o[5:3]), 32'd5);
        send_msg(1, 6, 0);
        #1 check_eq("gap_seq_upd", 32'({seq_upd_o, evt_sess_o}), {28'd0, 1'b1, 3'd1});
        send_ctl(1, 3);
        #1 check_eq("lo_cmd", 32'({cmd_valid_o, cmd_type_o, cmd_sess_o}), {24'd0, 1'b1, 4'd4, 3'd1});
        check_eq("lo_state", 32'(dbg_state_o[5:3]), 32'd6);

        // Back-pressure: full FIFO, then same-cycle pop frees a slot.
        do_reset();
        cmd_ready_i = 1'b0;
        for (int s = 0; s < 4; s++) send_ctl(s, 1);
        #1 check_eq("full_ready", 32'(msg_ready_o), 32'd0);
        cmd_ready_i = 1'b1;
        #1 check_eq("pop_ready", 32'(msg_ready_o), 32'd1);
        idle(6);

        // seqLow in HB_SENT drops the session; later traffic is discarded.
        do_reset();
        send_ctl(3, 1);
        send_msg(3, 1, 0);
        idle(16);
        #1 check_eq("s3_hb_sent", 32'(dbg_state_o[11:9]), 32'd3);
        send_msg(3, 7, 3);
        #1 check_eq("seqlow_disc", 32'({disc_o, evt_sess_o}), {28'd0, 1'b1, 3'd3});
        check_eq("seqlow_nocmd", 32'(cmd_valid_o), 32'd0);
        send_msg(3, 7, 0);
        #1 check_eq("disc_quiet", 32'({disc_o, seq_upd_o, app_msg_o, cmd_valid_o}), 32'd0);

        // Reset with commands queued.
        do_reset();
        cmd_ready_i = 1'b0;
        for (int s = 0; s < 3; s++) send_ctl(s, 1);
        #1 check_eq("queued_valid", 32'(cmd_valid_o), 32'd1);
        do_reset();

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            int r;
            if (k % 1000 == 999) do_reset();
            msg_valid_i    = ($urandom_range(0, 99) < 35);
            msg_sess_i     = SID_W'($urandom_range(0, NUM_SESS - 1));
            msg_type_i     = 4'($urandom_range(1, 7));
            r = $urandom_range(0, 19);
            msg_validity_i = (r < 10) ? 3'd0 : (r < 14) ? 3'd1 : (r < 16) ? 3'd2 : (r < 18) ? 3'd3 : 3'd4;
            ctl_valid_i    = ($urandom_range(0, 99) < 30);
            ctl_sess_i     = SID_W'($urandom_range(0, NUM_SESS - 1));
            ctl_op_i       = 2'($urandom_range(0, 3));
            cmd_ready_i    = ($urandom_range(0, 99) < 60);
            tick();
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
